// File: rtl/piso_framer_pkg.sv
// Serial-line definitions shared by the PISO framer and the downstream SISO receiver.
package piso_framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/piso_framer_bit_timer.sv
// Bit-period timer: tick marks the last clock cycle of each serial bit period.
module bit_timer
    import piso_framer_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic clr_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned   CW   = $clog2(BIT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_cnt <= '0;
        end else if (clear || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        tick = (r_cnt == LAST);
    end

endmodule

// File: rtl/piso_framer.sv
// Parallel-load serial framer: start bit, data LSB-first, optional parity, stop bit.
module piso_framer
    import piso_framer_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             data_out,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned   BW       = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic          ODD      = (PARITY_ODD != 0);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_shift;
    logic [BW-1:0]    r_bit_cnt;
    logic             r_parity;
    logic             r_alive;
    logic             w_tick;
    logic             w_xfer;
    logic             w_clear;

    bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .clr_n (clr_n),
        .clear (w_clear),
        .tick  (w_tick)
    );

    // Ready is decoded from state only; r_alive holds it low until the first edge after reset.
    always_comb begin
        load_ready = 1'b0;
        if (r_state == ST_IDLE) begin
            load_ready = r_alive;
        end else if (r_state == ST_STOP) begin
            load_ready = w_tick;
        end
    end

    always_comb begin
        w_xfer  = load_valid && load_ready;
        w_clear = (w_next != r_state) || (r_state == ST_IDLE);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        data_out   = LINE_IDLE;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (w_xfer) w_next = ST_START;
            end
            ST_START: begin
                data_out = START_LVL;
                if (w_tick) w_next = ST_DATA;
            end
            ST_DATA: begin
                data_out = r_shift[0];
                if (w_tick && (r_bit_cnt == LAST_BIT)) begin
                    w_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                data_out = r_parity;
                if (w_tick) w_next = ST_STOP;
            end
            ST_STOP: begin
                data_out = STOP_LVL;
                if (w_tick) begin
                    frame_done = 1'b1;
                    w_next     = w_xfer ? ST_START : ST_IDLE;
                end
            end
            default: begin
                busy   = 1'b0;
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_bit_cnt <= '0;
            r_alive   <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            if (w_xfer) begin
                r_shift  <= load_data;
                r_parity <= (^load_data) ^ ODD;
            end else if ((r_state == ST_DATA) && w_tick) begin
                r_shift <= r_shift >> 1;
            end
            if (w_next != r_state) begin
                r_bit_cnt <= '0;
            end else if ((r_state == ST_DATA) && w_tick) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_piso_framer.sv
// Bench for piso_framer: four parameter variants driven in lockstep against a frame-queue model.
module tb_piso_framer;

    localparam int PEN_T [4] = '{1, 1, 0, 1};
    localparam int ODD_T [4] = '{0, 1, 0, 0};
    localparam int BC_T  [4] = '{1, 1, 1, 3};

    logic       clk;
    logic       clr_n;
    logic [7:0] load_data;
    logic       load_valid;
    logic [3:0] rdyv;
    logic [3:0] dout;
    logic [3:0] busyv;
    logic [3:0] donev;

    logic [63:0] m_bits  [4];
    int          m_rem   [4];
    bit          m_alive [4];

    int n_total;
    int n_pass;
    int n_fail;

    piso_framer u0 (
        .clk(clk), .clr_n(clr_n), .load_data(load_data), .load_valid(load_valid),
        .load_ready(rdyv[0]), .data_out(dout[0]), .busy(busyv[0]), .frame_done(donev[0])
    );
    piso_framer #(.PARITY_ODD(1)) u1 (
        .clk(clk), .clr_n(clr_n), .load_data(load_data), .load_valid(load_valid),
        .load_ready(rdyv[1]), .data_out(dout[1]), .busy(busyv[1]), .frame_done(donev[1])
    );
    piso_framer #(.PARITY_EN(0)) u2 (
        .clk(clk), .clr_n(clr_n), .load_data(load_data), .load_valid(load_valid),
        .load_ready(rdyv[2]), .data_out(dout[2]), .busy(busyv[2]), .frame_done(donev[2])
    );
    piso_framer #(.BIT_CYCLES(3)) u3 (
        .clk(clk), .clr_n(clr_n), .load_data(load_data), .load_valid(load_valid),
        .load_ready(rdyv[3]), .data_out(dout[3]), .busy(busyv[3]), .frame_done(donev[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A frame is its list of line levels, each repeated for one bit period; the model consumes one per cycle.
    function automatic void model_load(input int i, input logic [7:0] w);
        bit fr[$];
        fr.push_back(1'b0);
        for (int j = 0; j < 8; j++) fr.push_back(w[j]);
        if (PEN_T[i] != 0) fr.push_back((^w) ^ (ODD_T[i] != 0));
        fr.push_back(1'b1);
        m_bits[i] = '0;
        m_rem[i]  = 0;
        foreach (fr[k]) begin
            for (int r = 0; r < BC_T[i]; r++) begin
                m_bits[i][m_rem[i]] = fr[k];
                m_rem[i]++;
            end
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_bits[i]  = '0;
            m_rem[i]   = 0;
            m_alive[i] = 1'b0;
        end
    endfunction

    function automatic void model_edge(input logic v, input logic [7:0] d);
        for (int i = 0; i < 4; i++) begin
            bit rdy;
            bit xfer;
            rdy  = m_alive[i] && (m_rem[i] <= 1);
            xfer = v && rdy;
            if (clr_n) begin
                m_alive[i] = 1'b1;
                if (m_rem[i] > 0) begin
                    m_bits[i] = m_bits[i] >> 1;
                    m_rem[i]--;
                end
                if (xfer) model_load(i, d);
            end
        end
    endfunction

    task automatic chk(input string tag, input int i, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s[u%0d] observed=%b expected=%b t=%0t", tag, i, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            chk("data_out",   i, dout[i],  (m_rem[i] > 0) ? m_bits[i][0] : 1'b1);
            chk("busy",       i, busyv[i], m_rem[i] > 0);
            chk("frame_done", i, donev[i], m_rem[i] == 1);
            chk("load_ready", i, rdyv[i],  m_alive[i] && (m_rem[i] <= 1));
        end
    endtask

    // Called at a negedge: drive inputs, let the edge happen, then check mid-cycle.
    task automatic step(input logic v, input logic [7:0] d);
        load_valid = v;
        load_data  = d;
        @(posedge clk);
        model_edge(v, d);
        @(negedge clk);
        check_all();
    endtask

    task automatic apply_reset(input int cycles);
        clr_n      = 1'b0;
        load_valid = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        repeat (cycles) step(1'b0, 8'h00);
        clr_n = 1'b1;
    endtask

    initial begin
        n_total    = 0;
        n_pass     = 0;
        n_fail     = 0;
        clr_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        model_reset();
        @(negedge clk);
        apply_reset(3);
        repeat (2) step(1'b0, 8'h00);

        step(1'b1, 8'hA5);
        repeat (36) step(1'b0, 8'h00);

        step(1'b1, 8'h01);
        repeat (11) step(1'b1, 8'h80);
        repeat (40) step(1'b0, 8'h00);

        step(1'b1, 8'h00);
        repeat (3) step(1'b0, 8'h00);
        repeat (8) step(1'b1, 8'hFF);
        repeat (40) step(1'b0, 8'h00);

        step(1'b1, 8'h07);
        repeat (36) step(1'b0, 8'h00);

        step(1'b1, 8'h96);
        repeat (4) step(1'b0, 8'h00);
        apply_reset(2);
        step(1'b0, 8'h00);
        step(1'b1, 8'h3C);
        repeat (36) step(1'b0, 8'h00);

        for (int it = 0; it < 30; it++) begin
            logic       v;
            logic [7:0] d;
            int         n;
            v = ($urandom_range(0, 2) != 0);
            d = 8'($urandom);
            n = $urandom_range(1, 12);
            repeat (n) step(v, d);
            if (it == 15) apply_reset(2);
        end
        repeat (40) step(1'b0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
